io_cycle_sequencer: RTL and testbench

Sequences Z80 I/O cycles on the I/O board CPLD onto the board's 4-to-16 device-select decoder. Qualifies each I/O request against the board base address and latches the low port nibble as the decoder select. Generates the decoder enable with guaranteed setup and hold around it, plus read/write strobes. Holds the CPU in wait states until the selected device's access window completes.

---
 rtl/io_cycle_sequencer_if.sv | 25 ++
 rtl/io_cycle_sequencer.sv | 123 ++++++++++++
 tb/tb_io_cycle_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/io_cycle_sequencer_if.sv
// CPU-side I/O request signals and decoder-side results of the I/O cycle sequencer.
// The master drives the Z80 request; the slave (sequencer) drives the decoder and WAIT.
interface io_cycle_sequencer_if;
    logic       iorq_n;
    logic       m1_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] addr;
    logic       dec_enable;
    logic [3:0] dec_sel;
    logic       rd_strobe;
    logic       wr_strobe;
    logic       wait_n;
    logic       busy;

    modport master (
        output iorq_n, m1_n, rd_n, wr_n, addr,
        input  dec_enable, dec_sel, rd_strobe, wr_strobe, wait_n, busy
    );

    modport slave (
        input  iorq_n, m1_n, rd_n, wr_n, addr,
        output dec_enable, dec_sel, rd_strobe, wr_strobe, wait_n, busy
    );
endinterface

// File: rtl/io_cycle_sequencer.sv
// Turns a qualified Z80 I/O cycle into a decoder select/enable sequence with setup,
// active and hold windows, holding the CPU in WAIT until the device access completes.
module io_cycle_sequencer #(
    parameter logic [3:0] BASE_NIBBLE = 4'h8,
    parameter int         SETUP_CYC   = 1,
    parameter int         ACTIVE_CYC  = 2,
    parameter int         HOLD_CYC    = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    io_cycle_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ACTIVE_LD = 4'(ACTIVE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       dir_rd, dir_rd_nxt;
    logic [3:0] sel_q, sel_nxt;
    logic       en_q, rds_q, wrs_q, wait_q, busy_q;
    logic       en_nxt, rds_nxt, wrs_nxt, wait_nxt, busy_nxt;
    logic       req;

    // Interrupt acknowledge (M1 with IORQ) and ambiguous direction never qualify.
    assign req = !bus.iorq_n && bus.m1_n && (bus.addr[7:4] == BASE_NIBBLE)
                 && (bus.rd_n ^ bus.wr_n);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dir_rd_nxt = dir_rd;
        sel_nxt    = sel_q;
        case (state)
            IDLE: begin
                if (req) begin
                    sel_nxt    = bus.addr[3:0];
                    dir_rd_nxt = !bus.rd_n;
                    if (SETUP_CYC == 0) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = ACTIVE_LD;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                    end
                end
            end
            SETUP, ACTIVE: begin
                // An early IORQ release ends the access but still honours hold time.
                if (bus.iorq_n || (state == ACTIVE && cnt == 4'd0)) begin
                    state_nxt = (HOLD_CYC == 0) ? DONE : HOLD;
                    cnt_nxt   = HOLD_LD;
                end else if (cnt == 4'd0) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = ACTIVE_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (bus.iorq_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        en_nxt   = (state_nxt == ACTIVE);
        rds_nxt  = en_nxt && dir_rd_nxt;
        wrs_nxt  = en_nxt && !dir_rd_nxt;
        wait_nxt = !((state_nxt == SETUP) || (state_nxt == ACTIVE));
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            dir_rd <= 1'b0;
            sel_q  <= 4'd0;
            en_q   <= 1'b0;
            rds_q  <= 1'b0;
            wrs_q  <= 1'b0;
            wait_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dir_rd <= dir_rd_nxt;
            sel_q  <= sel_nxt;
            en_q   <= en_nxt;
            rds_q  <= rds_nxt;
            wrs_q  <= wrs_nxt;
            wait_q <= wait_nxt;
            busy_q <= busy_nxt;
        end
    end

    assign bus.dec_enable = en_q;
    assign bus.dec_sel    = sel_q;
    assign bus.rd_strobe  = rds_q;
    assign bus.wr_strobe  = wrs_q;
    assign bus.wait_n     = wait_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_io_cycle_sequencer.sv
// Drives two sequencers (default timing and zero setup/hold) with identical CPU cycles
// and compares every output each clock against a window-based timeline model.
module tb_io_cycle_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_cycle_sequencer_if bus_a ();
    io_cycle_sequencer_if bus_b ();

    localparam int SA = 1, AA = 2, HA = 1;
    localparam int SB = 0, AB = 1, HB = 0;

    io_cycle_sequencer #(.BASE_NIBBLE(4'h8), .SETUP_CYC(SA), .ACTIVE_CYC(AA), .HOLD_CYC(HA))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    io_cycle_sequencer #(.BASE_NIBBLE(4'h8), .SETUP_CYC(SB), .ACTIVE_CYC(AB), .HOLD_CYC(HB))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    localparam int ST_IDLE = 0, ST_SETUP = 1, ST_ACT = 2, ST_HOLD = 3, ST_DONE = 4;

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] last_sel;

    // Observed vector: {enable, rd_strobe, wr_strobe, wait_n, busy, sel[3:0]}
    logic [8:0] obs_a, obs_b;
    assign obs_a = {bus_a.dec_enable, bus_a.rd_strobe, bus_a.wr_strobe,
                    bus_a.wait_n, bus_a.busy, bus_a.dec_sel};
    assign obs_b = {bus_b.dec_enable, bus_b.rd_strobe, bus_b.wr_strobe,
                    bus_b.wait_n, bus_b.busy, bus_b.dec_sel};

    // Edge index (counted from the accepting edge E0 = 0) where the enable window ends.
    function automatic int end_act(int s, int a, int r);
        return (r <= s + a) ? r : s + a;
    endfunction

    function automatic int idle_at(int s, int a, int h, int r);
        int d;
        d = end_act(s, a, r) + h;
        return (d + 1 > r) ? d + 1 : r;
    endfunction

    // r = first edge index at which iorq_n is sampled high (r >= 1).
    function automatic int exp_st(int k, int s, int a, int h, int r);
        int e, d;
        e = end_act(s, a, r);
        d = e + h;
        if (k >= idle_at(s, a, h, r)) return ST_IDLE;
        if (k >= d) return ST_DONE;
        if (k >= e) return ST_HOLD;
        if (k >= s) return ST_ACT;
        return ST_SETUP;
    endfunction

    function automatic logic [8:0] exp_vec(int st, logic rd, logic [3:0] sel);
        logic en;
        en = (st == ST_ACT);
        return {en, en && rd, en && !rd,
                !(st == ST_SETUP || st == ST_ACT), st != ST_IDLE, sel};
    endfunction

    task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed={en,rd,wr,wait,busy,sel}=%09b required=%09b",
                   tag, obs, exp);
        end
    endtask

    task automatic drive(logic iorq, logic m1, logic rd, logic wr, logic [7:0] a);
        bus_a.iorq_n = iorq; bus_a.m1_n = m1; bus_a.rd_n = rd; bus_a.wr_n = wr; bus_a.addr = a;
        bus_b.iorq_n = iorq; bus_b.m1_n = m1; bus_b.rd_n = rd; bus_b.wr_n = wr; bus_b.addr = a;
    endtask

    task automatic set_iorq(logic v);
        bus_a.iorq_n = v;
        bus_b.iorq_n = v;
    endtask

    task automatic set_addr(logic [7:0] a);
        bus_a.addr = a;
        bus_b.addr = a;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One qualified cycle: drive it, clock E0, then check both DUTs until both are idle.
    task automatic run_txn(string tag, logic [7:0] a, logic rd, int r,
                           bit scramble, int chg_k, logic [7:0] chg_a);
        int kend, ia, ib;
        logic [7:0] ra;
        logic [2:0] rb;
        ia = idle_at(SA, AA, HA, r);
        ib = idle_at(SB, AB, HB, r);
        kend = (ia > ib) ? ia : ib;
        drive(1'b0, 1'b1, !rd, rd, a);
        tick;
        for (int k = 0; k <= kend; k++) begin
            chk({tag, "_a"}, obs_a, exp_vec(exp_st(k, SA, AA, HA, r), rd, a[3:0]));
            chk({tag, "_b"}, obs_b, exp_vec(exp_st(k, SB, AB, HB, r), rd, a[3:0]));
            if (k == kend) break;
            if (k + 1 >= r) set_iorq(1'b1);
            if (k == chg_k) set_addr(chg_a);
            if (scramble) begin
                ra = 8'($urandom);
                rb = 3'($urandom);
                bus_a.addr = ra; bus_a.m1_n = rb[0]; bus_a.rd_n = rb[1]; bus_a.wr_n = rb[2];
                bus_b.addr = ra; bus_b.m1_n = rb[0]; bus_b.rd_n = rb[1]; bus_b.wr_n = rb[2];
            end
            tick;
        end
        last_sel = a[3:0];
    endtask

    task automatic reject(string tag, logic [7:0] a, logic m1, logic rd, logic wr, int n);
        drive(1'b0, m1, rd, wr, a);
        for (int k = 0; k < n; k++) begin
            tick;
            chk({tag, "_a"}, obs_a, exp_vec(ST_IDLE, 1'b0, last_sel));
            chk({tag, "_b"}, obs_b, exp_vec(ST_IDLE, 1'b0, last_sel));
        end
        set_iorq(1'b1);
        tick;
    endtask

    task automatic idle_check(string tag, int n);
        set_iorq(1'b1);
        for (int k = 0; k < n; k++) begin
            tick;
            chk({tag, "_a"}, obs_a, exp_vec(ST_IDLE, 1'b0, last_sel));
            chk({tag, "_b"}, obs_b, exp_vec(ST_IDLE, 1'b0, last_sel));
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic       rm1, rrd, rwr;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        last_sel = 4'd0;

        // Reset state
        repeat (2) tick;
        chk("reset_a", obs_a, exp_vec(ST_IDLE, 1'b0, 4'd0));
        chk("reset_b", obs_b, exp_vec(ST_IDLE, 1'b0, 4'd0));
        #3 rst_n = 1'b1;
        idle_check("post_reset", 2);

        // Default write to 0x85, iorq released well after the access
        run_txn("wr85", 8'h85, 1'b0, 7, 1'b0, -1, 8'h00);

        // Rejected cycles
        reject("rej_base", 8'h3A, 1'b1, 1'b0, 1'b1, 3);
        reject("rej_inta", 8'h8F, 1'b0, 1'b1, 1'b1, 3);
        reject("rej_both", 8'h82, 1'b1, 1'b0, 1'b0, 3);
        reject("rej_none", 8'h82, 1'b1, 1'b1, 1'b1, 2);

        // Address change mid-access is ignored; select persists in idle
        run_txn("rd8f", 8'h8F, 1'b1, 6, 1'b0, 1, 8'h80);
        idle_check("idle_sel", 3);

        // Short cycle (checked on dut_b) and minimum turnaround
        run_txn("rd81", 8'h81, 1'b1, 2, 1'b0, -1, 8'h00);
        run_txn("rd81_fast", 8'h81, 1'b1, 1, 1'b0, -1, 8'h00);

        // Abort during the first active clock of dut_a
        run_txn("abort8c", 8'h8C, 1'b0, 2, 1'b0, -1, 8'h00);
        run_txn("abort_setup", 8'h84, 1'b0, 1, 1'b0, -1, 8'h00);

        // Reset pulsed mid-ACTIVE with the request held across release
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h86);
        tick;
        chk("pre_rst0_a", obs_a, exp_vec(exp_st(0, SA, AA, HA, 99), 1'b0, 4'h6));
        tick;
        chk("pre_rst1_a", obs_a, exp_vec(exp_st(1, SA, AA, HA, 99), 1'b0, 4'h6));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a", obs_a, exp_vec(ST_IDLE, 1'b0, 4'd0));
        chk("async_rst_b", obs_b, exp_vec(ST_IDLE, 1'b0, 4'd0));
        last_sel = 4'd0;
        tick;
        chk("in_rst_a", obs_a, exp_vec(ST_IDLE, 1'b0, 4'd0));
        chk("in_rst_b", obs_b, exp_vec(ST_IDLE, 1'b0, 4'd0));
        #3 rst_n = 1'b1;
        run_txn("after_rst", 8'h86, 1'b0, 5, 1'b0, -1, 8'h00);

        // Randomized cycles, qualified or not, with noise on the bus after acceptance
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ra[7:4] = 4'h8;
            rm1 = ($urandom_range(0, 5) != 0);
            rrd = 1'($urandom);
            rwr = 1'($urandom);
            if (rm1 && ra[7:4] == 4'h8 && (rrd ^ rwr))
                run_txn("rand_txn", ra, !rrd, int'($urandom_range(1, 10)), 1'b1, -1, 8'h00);
            else
                reject("rand_rej", ra, rm1, rrd, rwr, 2);
        end
        idle_check("final_idle", 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
